// File: rtl/aes_round_controller_if.sv
// Block-side handshake bundle of the AES round controller.
// Ports: start/abort/out_ready toward the controller;
//   in_ready/out_valid/result (128b) back to the bus wrapper.
interface aes_round_controller_if;
   logic         start;
   logic         in_ready;
   logic         abort;
   logic [127:0] result;
   logic         out_valid;
   logic         out_ready;

   // Bus wrapper side
   modport master (
      output start,
      output abort,
      output out_ready,
      input  in_ready,
      input  result,
      input  out_valid
   );

   // Controller side
   modport slave (
      input  start,
      input  abort,
      input  out_ready,
      output in_ready,
      output result,
      output out_valid
   );
endinterface

// File: rtl/aes_round_controller.sv
// Sequencer for the iterative AES encryption datapath.
// Ports: clk, rst_n (async, active low); bus (handshake bundle);
//   select_line, state_load, round_num, key_step, last_round,
//   busy to the datapath; round_state (128b) from the datapath.
module aes_round_controller #(
   parameter int NUM_ROUNDS = 10,
   parameter int ROUND_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   aes_round_controller_if.slave bus,
   output logic               select_line,
   output logic               state_load,
   output logic [ROUND_W-1:0] round_num,
   output logic               key_step,
   output logic               last_round,
   output logic               busy,
   input  logic [127:0]       round_state
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL,
      HOLD
   } state_e;

   localparam logic [ROUND_W-1:0] CNT_PRE_FINAL =
      ROUND_W'(NUM_ROUNDS - 1);
   localparam logic [ROUND_W-1:0] CNT_FINAL =
      ROUND_W'(NUM_ROUNDS);

   state_e               state_q, state_d;
   logic [ROUND_W-1:0]   cnt_q, cnt_d;
   logic [127:0]         result_q, result_d;

   logic                 in_ready_c;
   logic                 out_valid_c;
   logic                 select_c;
   logic                 load_c;
   logic                 key_c;
   logic                 last_c;
   logic                 busy_c;
   logic [ROUND_W-1:0]   round_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Outputs depend only on state_q/cnt_q; inputs
   // only steer the next-state terms.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      select_c    = 1'b0;
      load_c      = 1'b0;
      key_c       = 1'b0;
      last_c      = 1'b0;
      busy_c      = 1'b0;
      round_c     = '0;

      unique case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            cnt_d      = '0;
            // abort in IDLE swallows a same-cycle start
            if (bus.start && !bus.abort) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            load_c  = 1'b1;
            key_c   = 1'b1;
            busy_c  = 1'b1;
            round_c = cnt_q;
            cnt_d   = ROUND_W'(1);
            state_d = ROUND;
         end
         ROUND: begin
            select_c = 1'b1;
            load_c   = 1'b1;
            key_c    = 1'b1;
            busy_c   = 1'b1;
            round_c  = cnt_q;
            cnt_d    = cnt_q + ROUND_W'(1);
            if (cnt_q == CNT_PRE_FINAL) begin
               state_d = FINAL;
            end
         end
         FINAL: begin
            select_c = 1'b1;
            load_c   = 1'b1;
            last_c   = 1'b1;
            busy_c   = 1'b1;
            round_c  = cnt_q;
            result_d = round_state;
            cnt_d    = '0;
            state_d  = HOLD;
         end
         HOLD: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // abort wins over every transition and never
      // lets a partial block reach result
      if (bus.abort && state_q != IDLE) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.result    = result_q;
   assign select_line   = select_c;
   assign state_load    = load_c;
   assign key_step      = key_c;
   assign last_round    = last_c;
   assign busy          = busy_c;
   assign round_num     = round_c;

   a_round_range: assert property (
      @(posedge clk) disable iff (!rst_n)
      round_num <= CNT_FINAL
   );

   a_last_at_final: assert property (
      @(posedge clk) disable iff (!rst_n)
      last_round |-> (round_num == CNT_FINAL)
   );

   a_valid_not_busy: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(out_valid_c && busy_c)
   );

endmodule

// File: tb/tb_aes_round_controller.sv
// Scoreboard bench for aes_round_controller.
// Three instances: NUM_ROUNDS 10 (main), 2 and 14 (sweep).
module tb_aes_round_controller;

   localparam logic [127:0] V1 =
      128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] V2 =
      128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V3 =
      128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] JUNK =
      128'hdeadbeef_cafef00d_0badc0de_55aa33cc;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aes_round_controller_if bus0 ();
   aes_round_controller_if bus2 ();
   aes_round_controller_if bus14 ();

   logic         sel0, ld0, ks0, lr0, bz0;
   logic [3:0]   rn0;
   logic [127:0] rs0;
   logic         sel2, ld2, ks2, lr2, bz2;
   logic [3:0]   rn2;
   logic         sel14, ld14, ks14, lr14, bz14;
   logic [3:0]   rn14;

   aes_round_controller #(.NUM_ROUNDS(10), .ROUND_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0),
      .select_line(sel0), .state_load(ld0),
      .round_num(rn0), .key_step(ks0),
      .last_round(lr0), .busy(bz0),
      .round_state(rs0)
   );

   aes_round_controller #(.NUM_ROUNDS(2), .ROUND_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2),
      .select_line(sel2), .state_load(ld2),
      .round_num(rn2), .key_step(ks2),
      .last_round(lr2), .busy(bz2),
      .round_state(V2)
   );

   aes_round_controller #(.NUM_ROUNDS(14), .ROUND_W(4)) u_dut14 (
      .clk(clk), .rst_n(rst_n), .bus(bus14),
      .select_line(sel14), .state_load(ld14),
      .round_num(rn14), .key_step(ks14),
      .last_round(lr14), .busy(bz14),
      .round_state(V3)
   );

   int tests = 0;
   int fails = 0;
   logic [127:0] exp_q[$];

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [10:0] ctl0();
      return {bus0.in_ready, bus0.out_valid, bz0, sel0,
              ld0, ks0, lr0, rn0};
   endfunction

   function automatic logic [10:0] mk(
      input bit ir, input bit ov, input bit bz,
      input bit sl, input bit ld, input bit ks,
      input bit lr, input int rn);
      return {ir, ov, bz, sl, ld, ks, lr, 4'(rn)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a transfer is out_valid & out_ready
   // without abort, seen mid-cycle.
   always @(negedge clk) begin
      if (rst_n && bus0.out_valid && bus0.out_ready
          && !bus0.abort) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %h want none",
                     bus0.result);
         end else begin
            chk("scoreboard_result", bus0.result,
                exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int loads, loads2, loads14, lr2n, lr14n;
      int t1, t2;
      bit saw_valid;

      rst_n = 1'b0;
      bus0.start = 0; bus0.abort = 0; bus0.out_ready = 0;
      bus2.start = 0; bus2.abort = 0; bus2.out_ready = 1;
      bus14.start = 0; bus14.abort = 0; bus14.out_ready = 1;
      rs0 = JUNK;

      #3;
      chk("reset_ctrl", ctl0(), mk(1,0,0,0,0,0,0,0));
      chk("reset_result", bus0.result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_after_reset", ctl0(), mk(1,0,0,0,0,0,0,0));

      // Full block, FIPS-197 ciphertext at FINAL
      exp_q.push_back(V1);
      bus0.start = 1;
      tick();
      bus0.start = 0;
      loads = 0;
      for (int k = 0; k <= 10; k++) begin
         rs0 = (k == 10) ? V1 : (JUNK ^ 128'(k));
         chk($sformatf("run_k%0d", k), ctl0(),
             mk(0,0,1,k>0,1,k<10,k==10,k));
         if (ld0) loads++;
         tick();
      end
      rs0 = JUNK;
      chk("hold_after_e11", ctl0(), mk(0,1,0,0,0,0,0,0));
      chk("load_count_10", loads, 11);

      // HOLD stall, start ignored
      for (int i = 0; i < 5; i++) begin
         bus0.start = (i == 2);
         chk("hold_stall_ctrl", ctl0(), mk(0,1,0,0,0,0,0,0));
         chk("hold_stall_result", bus0.result, V1);
         tick();
      end
      bus0.start = 0;
      bus0.out_ready = 1;
      tick();
      bus0.out_ready = 0;
      chk("hold_release", ctl0(), mk(1,0,0,0,0,0,0,0));
      tick();
      chk("start_not_queued", ctl0(), mk(1,0,0,0,0,0,0,0));

      // abort at round 4
      rs0 = V2;
      bus0.start = 1;
      tick();
      bus0.start = 0;
      repeat (4) tick();
      chk("round4_reached", rn0, 4);
      bus0.abort = 1;
      tick();
      bus0.abort = 0;
      chk("abort_idle", ctl0(), mk(1,0,0,0,0,0,0,0));
      chk("abort_keeps_result", bus0.result, V1);
      saw_valid = 0;
      repeat (15) begin
         tick();
         if (bus0.out_valid) saw_valid = 1;
      end
      chk("abort_no_valid", saw_valid, 0);

      // async reset mid-ROUND
      bus0.start = 1;
      tick();
      bus0.start = 0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_ctrl", ctl0(), mk(1,0,0,0,0,0,0,0));
      chk("async_rst_result", bus0.result, '0);
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst_idle", ctl0(), mk(1,0,0,0,0,0,0,0));

      // start+abort in IDLE
      bus0.start = 1;
      bus0.abort = 1;
      tick();
      chk("start_abort_idle", ctl0(), mk(1,0,0,0,0,0,0,0));
      bus0.start = 0;
      bus0.abort = 0;
      tick();
      chk("start_abort_idle2", ctl0(), mk(1,0,0,0,0,0,0,0));

      // abort+out_ready in HOLD
      rs0 = V3;
      bus0.start = 1;
      tick();
      bus0.start = 0;
      for (int n = 0; n < 30 && !bus0.out_valid; n++) tick();
      chk("hold_reached", bus0.out_valid, 1);
      bus0.abort = 1;
      bus0.out_ready = 1;
      tick();
      bus0.abort = 0;
      bus0.out_ready = 0;
      chk("abort_in_hold", ctl0(), mk(1,0,0,0,0,0,0,0));

      // throughput with start/out_ready held high
      exp_q.push_back(V3);
      exp_q.push_back(V3);
      bus0.out_ready = 1;
      bus0.start = 1;
      t1 = -1;
      t2 = -1;
      for (int c = 0; c < 60 && t2 < 0; c++) begin
         if (bus0.out_valid) begin
            if (t1 < 0) t1 = c;
            else begin
               t2 = c;
               bus0.start = 0;
            end
         end
         if (t2 < 0) tick();
      end
      bus0.start = 0;
      chk("throughput", t2 - t1, 13);
      tick();
      bus0.out_ready = 0;
      chk("throughput_idle", ctl0(), mk(1,0,0,0,0,0,0,0));

      // parameter sweep 2 and 14
      bus2.start = 1;
      bus14.start = 1;
      tick();
      bus2.start = 0;
      bus14.start = 0;
      loads2 = 0; loads14 = 0; lr2n = 0; lr14n = 0;
      for (int i = 0; i < 20; i++) begin
         if (ld2) loads2++;
         if (ld14) loads14++;
         if (lr2) lr2n++;
         if (lr14) lr14n++;
         chk("nr2_last", lr2, rn2 == 4'd2);
         chk("nr14_last", lr14, rn14 == 4'd14);
         tick();
      end
      chk("nr2_loads", loads2, 3);
      chk("nr14_loads", loads14, 15);
      chk("nr2_last_count", lr2n, 1);
      chk("nr14_last_count", lr14n, 1);
      chk("nr2_idle", bus2.in_ready, 1);
      chk("nr14_idle", bus14.in_ready, 1);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aes_round_controller.md
# aes_round_controller

Sequencer for the iterative AES-128 encryption datapath. It accepts a block-start request and drives the 128-bit 2:1 state mux select, the state-register load enable, the round index, the key-expansion step and the final-round flag. It captures the finished ciphertext into an output buffer and presents it with a valid/ready handshake. It sits between the system bus wrapper and the round datapath: it owns all control, while the datapath owns all 128-bit state arithmetic.

## Interface
Parameters:
- NUM_ROUNDS, 10, total AES rounds; legal 2..15 (10/12/14 for AES-128/192/256 key schedules)
- ROUND_W, 4, width of round_num; must hold NUM_ROUNDS

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to encrypt the block currently on the datapath input; accepted when start & in_ready
- in_ready  out  1  controller idle and able to accept start
- abort  in  1  synchronous abandon of the current operation
- select_line  out  1  mux select: 0 = initial (whitened) input, 1 = round feedback
- state_load  out  1  load enable for the datapath state register
- round_num  out  ROUND_W  current round index, 0..NUM_ROUNDS, to the round-key generator
- key_step  out  1  advance the key schedule by one round at this edge
- last_round  out  1  final round; the datapath bypasses MixColumns
- busy  out  1  operation in progress (LOAD, ROUND or FINAL)
- round_state  in  128  combinational round-logic output from the datapath
- result  out  128  registered ciphertext
- out_valid  out  1  result holds a finished block
- out_ready  in  1  consumer accepts result

## Operation
FSM states are IDLE, LOAD, ROUND, FINAL and HOLD. All control outputs are decoded from the state and a registered round counter, with no combinational path from inputs.

- IDLE: in_ready=1. All other controls are 0 and round_num=0. If start is high at an edge, the next state is LOAD.
- LOAD (1 cycle): select_line=0, state_load=1, key_step=1, round_num=0, busy=1. The next state is ROUND and the counter becomes 1.
- ROUND (NUM_ROUNDS-1 cycles, round_num=1..NUM_ROUNDS-1): select_line=1, state_load=1, key_step=1, last_round=0, busy=1.
  - The counter increments each edge.
  - When round_num==NUM_ROUNDS-1, the next state is FINAL.
- FINAL (1 cycle): select_line=1, state_load=1, last_round=1, key_step=0, round_num=NUM_ROUNDS, busy=1.
  - At the closing edge, result is loaded with round_state.
  - The next state is HOLD.
- HOLD: out_valid=1, in_ready=0, all datapath controls 0, round_num=0.
  - result is stable.
  - If out_ready is high at an edge, the next state is IDLE; out_valid drops at that edge.
- abort: high at an edge in LOAD, ROUND, FINAL or HOLD forces the next state to IDLE and clears out_valid.
  - result is not written.
  - abort has priority over every other transition.
  - abort in IDLE has no effect, and a start in the same cycle is ignored.
- start outside IDLE is ignored and is not queued.
- After HOLD->IDLE, in_ready=1 on the following cycle. There is no back-to-back bypass.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, result=128'h0.
  - Outputs during and after reset: in_ready=1, out_valid=0, busy=0, select_line=0, state_load=0, key_step=0, last_round=0, round_num=0.
  - Reset mid-round discards the block with no partial result.
- Latency: start is accepted at edge E0, and out_valid rises after edge E0+NUM_ROUNDS+1 (edge 11 for NUM_ROUNDS=10).
- Counting from E0, state_load is high for exactly NUM_ROUNDS+1 consecutive cycles, and select_line=0 in only the first of them.
- Throughput: one block per NUM_ROUNDS+3 cycles when out_ready is held high.
- round_num never exceeds NUM_ROUNDS and never wraps; the counter is cleared on entry to IDLE.

## Test plan
- Reset, then start pulse, NUM_ROUNDS=10:
  - select_line=0 for 1 cycle, then 1 for 10 cycles.
  - round_num sequence is 0,1,…,10; last_round is high only when round_num=10; key_step is high for 10 cycles.
  - out_valid rises at edge 11, and result equals the round_state value driven during FINAL (e.g. 128'h3925841d02dc09fbdc118597196a0b32 for the FIPS-197 vector).
- out_ready held low 5 cycles in HOLD: out_valid and result stay stable; a start pulse during HOLD is ignored (in_ready=0); out_ready=1 returns to IDLE in 1 edge.
- abort asserted during ROUND at round_num=4: next cycle is IDLE with round_num=0, busy=0, and out_valid never asserts; the previous result is unchanged.
- rst_n asserted asynchronously mid-ROUND: all outputs reach reset values before the next clock edge, and result=0.
- Simultaneous start and abort in IDLE: the controller stays in IDLE. Simultaneous out_ready and abort in HOLD: the next state is IDLE and out_valid=0.
- Parameter sweep with NUM_ROUNDS=2 and 14: the total state_load cycles are 3 and 15 respectively, and last_round is high only when round_num=NUM_ROUNDS.
